// File: rtl/mem_access.sv
// Memory-access stage: passes ALU results to write-back in one cycle and runs
// LDR/STR(B) through a request/acknowledge data-memory port, stalling upstream while busy.
module mem_access (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] alu_data_i,
    input  logic [31:0] store_data_i,
    input  logic [3:0]  rd_addr_i,
    input  logic        do_write_i,
    input  logic        cond_met_i,
    input  logic        valid_i,
    input  logic        flush_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] wb_data_o,
    output logic [3:0]  wb_addr_o,
    output logic        wb_en_o,
    output logic        stall_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        w_live;
    logic        w_is_mem;
    logic        w_accept_mem;
    logic        w_accept_alu;
    logic        w_done;

    logic        r_we;
    logic        r_byte;
    logic [1:0]  r_lane;
    logic [3:0]  r_rd;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;

    logic [3:0]  w_be_in;
    logic [31:0] w_wdata_in;
    logic [7:0]  w_load_byte;
    logic [31:0] w_load_data;

    logic [31:0] r_wb_data;
    logic [3:0]  r_wb_addr;
    logic        r_wb_en;

    logic        w_unused;

    assign w_live   = valid_i & ~flush_i & cond_met_i;
    assign w_is_mem = (inst_i[27:26] == 2'b01);

    always_comb begin
        w_next_state = r_state;
        w_accept_mem = 1'b0;
        w_accept_alu = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_live) begin
                    if (w_is_mem) begin
                        w_accept_mem = 1'b1;
                        w_next_state = BUSY;
                    end else begin
                        w_accept_alu = 1'b1;
                    end
                end
            end
            BUSY: begin
                // Flush is deliberately not looked at here: the access in flight is older than the branch.
                if (dmem_ack_i) begin
                    w_done       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign w_be_in    = inst_i[22] ? (4'b0001 << alu_data_i[1:0]) : 4'hF;
    assign w_wdata_in = inst_i[22] ? {4{store_data_i[7:0]}} : store_data_i;

    // Byte enables and write data are registered at acceptance so the port never sees inst_i directly.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_we    <= 1'b0;
            r_byte  <= 1'b0;
            r_lane  <= 2'b00;
            r_rd    <= 4'h0;
            r_addr  <= 32'h0;
            r_be    <= 4'h0;
            r_wdata <= 32'h0;
        end else if (w_accept_mem) begin
            r_we    <= ~inst_i[20];
            r_byte  <= inst_i[22];
            r_lane  <= alu_data_i[1:0];
            r_rd    <= rd_addr_i;
            r_addr  <= {alu_data_i[31:2], 2'b00};
            r_be    <= w_be_in;
            r_wdata <= w_wdata_in;
        end
    end

    always_comb begin
        w_load_byte = dmem_rdata_i[7:0];
        case (r_lane)
            2'd0: w_load_byte = dmem_rdata_i[7:0];
            2'd1: w_load_byte = dmem_rdata_i[15:8];
            2'd2: w_load_byte = dmem_rdata_i[23:16];
            2'd3: w_load_byte = dmem_rdata_i[31:24];
            default: w_load_byte = dmem_rdata_i[7:0];
        endcase
    end

    assign w_load_data = r_byte ? {24'h0, w_load_byte} : dmem_rdata_i;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wb_data <= 32'h0;
            r_wb_addr <= 4'h0;
            r_wb_en   <= 1'b0;
        end else begin
            r_wb_en <= 1'b0;
            if (w_accept_alu) begin
                r_wb_data <= alu_data_i;
                r_wb_addr <= rd_addr_i;
                r_wb_en   <= do_write_i;
            end else if (w_done && !r_we) begin
                r_wb_data <= w_load_data;
                r_wb_addr <= r_rd;
                r_wb_en   <= 1'b1;
            end
        end
    end

    assign dmem_req_o   = (r_state == BUSY);
    assign stall_o      = (r_state == BUSY);
    assign dmem_we_o    = r_we;
    assign dmem_addr_o  = r_addr;
    assign dmem_be_o    = r_be;
    assign dmem_wdata_o = r_wdata;

    assign wb_data_o = r_wb_data;
    assign wb_addr_o = r_wb_addr;
    assign wb_en_o   = r_wb_en;

    assign w_unused = ^{inst_i[31:28], inst_i[25:23], inst_i[21], inst_i[19:0]};

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios with literal expectations, then random
// traffic against a transaction-level model with reference memory and a load scoreboard.
module tb_mem_access;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] inst_i;
    logic [31:0] alu_data_i;
    logic [31:0] store_data_i;
    logic [3:0]  rd_addr_i;
    logic        do_write_i;
    logic        cond_met_i;
    logic        valid_i;
    logic        flush_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic [31:0] wb_data_o;
    logic [3:0]  wb_addr_o;
    logic        wb_en_o;
    logic        stall_o;

    localparam logic [31:0] ADD_I  = 32'hE081_0002;
    localparam logic [31:0] LDR_I  = 32'hE591_2000;
    localparam logic [31:0] LDRB_I = 32'hE5D1_2000;
    localparam logic [31:0] STR_I  = 32'hE581_2000;
    localparam logic [31:0] STRB_I = 32'hE5C1_2000;

    mem_access dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .inst_i       (inst_i),
        .alu_data_i   (alu_data_i),
        .store_data_i (store_data_i),
        .rd_addr_i    (rd_addr_i),
        .do_write_i   (do_write_i),
        .cond_met_i   (cond_met_i),
        .valid_i      (valid_i),
        .flush_i      (flush_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_rdata_i (dmem_rdata_i),
        .wb_data_o    (wb_data_o),
        .wb_addr_o    (wb_addr_o),
        .wb_en_o      (wb_en_o),
        .stall_o      (stall_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Model: one outstanding transaction, reference memory, expected load results queue.
    logic [31:0] exp_q[$];
    logic [31:0] ref_mem [16];
    logic [31:0] resp_mem[16];
    bit          m_busy;
    bit          m_any;
    logic        m_we;
    logic        m_byte;
    logic [31:0] m_addr;
    logic [31:0] m_store;
    logic [3:0]  m_rd;
    logic [31:0] e_wb_data;
    logic [3:0]  e_wb_addr;
    logic        e_wb_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%08h expected=%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy    = 0;
        m_any     = 0;
        m_we      = 0;
        m_byte    = 0;
        m_addr    = 0;
        m_store   = 0;
        m_rd      = 0;
        e_wb_data = 0;
        e_wb_addr = 0;
        e_wb_en   = 0;
        exp_q.delete();
    endtask

    function automatic logic [31:0] expected_load(input logic [31:0] a, input logic b);
        logic [31:0] w;
        w = ref_mem[a[5:2]];
        if (b) return (w >> (8 * a[1:0])) & 32'hFF;
        return w;
    endfunction

    // Advance the model across the coming rising edge using the inputs now applied.
    task automatic model_edge();
        logic [31:0] w;
        e_wb_en = 0;
        if (!m_busy) begin
            if (valid_i && !flush_i && cond_met_i) begin
                if (inst_i[27:26] == 2'b01) begin
                    m_busy  = 1;
                    m_any   = 1;
                    m_we    = !inst_i[20];
                    m_byte  = inst_i[22];
                    m_addr  = alu_data_i;
                    m_store = store_data_i;
                    m_rd    = rd_addr_i;
                    if (!m_we) exp_q.push_back(expected_load(alu_data_i, inst_i[22]));
                end else begin
                    e_wb_data = alu_data_i;
                    e_wb_addr = rd_addr_i;
                    e_wb_en   = do_write_i;
                end
            end
        end else if (dmem_ack_i) begin
            m_busy = 0;
            if (m_we) begin
                w = ref_mem[m_addr[5:2]];
                if (m_byte) w[8*m_addr[1:0] +: 8] = m_store[7:0];
                else        w = m_store;
                ref_mem[m_addr[5:2]] = w;
            end else begin
                e_wb_en   = 1;
                e_wb_addr = m_rd;
                e_wb_data = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0]  eb;
        logic [31:0] ewd;
        eb  = m_byte ? (4'b0001 << m_addr[1:0]) : 4'hF;
        ewd = m_byte ? {4{m_store[7:0]}} : m_store;
        check("stall", {31'b0, stall_o}, {31'b0, m_busy});
        check("req", {31'b0, dmem_req_o}, {31'b0, m_busy});
        check("wb_en", {31'b0, wb_en_o}, {31'b0, e_wb_en});
        check("wb_addr", {28'b0, wb_addr_o}, {28'b0, e_wb_addr});
        check("wb_data", wb_data_o, e_wb_data);
        if (m_busy) begin
            check("dmem_we", {31'b0, dmem_we_o}, {31'b0, m_we});
            check("dmem_addr", dmem_addr_o, {m_addr[31:2], 2'b00});
            check("dmem_be", {28'b0, dmem_be_o}, {28'b0, eb});
            check("dmem_wdata", dmem_wdata_o, ewd);
        end else if (!m_any) begin
            check("dmem_we_rst", {31'b0, dmem_we_o}, 32'h0);
            check("dmem_addr_rst", dmem_addr_o, 32'h0);
            check("dmem_be_rst", {28'b0, dmem_be_o}, 32'h0);
            check("dmem_wdata_rst", dmem_wdata_o, 32'h0);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk_i);
        @(negedge clk_i);
        compare_all();
    endtask

    task automatic set_idle();
        valid_i      = 0;
        flush_i      = 0;
        cond_met_i   = 1;
        do_write_i   = 0;
        inst_i       = 32'h0;
        alu_data_i   = 32'h0;
        store_data_i = 32'h0;
        rd_addr_i    = 4'h0;
        dmem_ack_i   = 0;
        dmem_rdata_i = 32'h0;
    endtask

    task automatic issue(input logic [31:0] inst, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [3:0] rd, input logic dw);
        valid_i      = 1;
        flush_i      = 0;
        cond_met_i   = 1;
        inst_i       = inst;
        alu_data_i   = alu;
        store_data_i = sd;
        rd_addr_i    = rd;
        do_write_i   = dw;
    endtask

    // Memory responder: acks a pending request at random, applying stores by byte enable.
    task automatic respond();
        logic [31:0] w;
        dmem_rdata_i = $urandom;
        if (dmem_req_o) begin
            dmem_ack_i = ($urandom_range(0, 2) == 0);
            w = resp_mem[dmem_addr_o[5:2]];
            if (dmem_ack_i) begin
                if (dmem_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (dmem_be_o[b]) w[8*b +: 8] = dmem_wdata_o[8*b +: 8];
                    resp_mem[dmem_addr_o[5:2]] = w;
                end else begin
                    dmem_rdata_i = w;
                end
            end
        end else begin
            dmem_ack_i = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic randomize_inputs();
        logic [31:0] r;
        valid_i    = ($urandom_range(0, 9) < 8);
        flush_i    = ($urandom_range(0, 9) == 0);
        cond_met_i = ($urandom_range(0, 19) < 17);
        do_write_i = $urandom_range(0, 1);
        rd_addr_i  = 4'($urandom_range(0, 15));
        store_data_i = $urandom;
        r = $urandom;
        if ($urandom_range(0, 1) == 1) begin
            r[27:26]   = 2'b01;
            alu_data_i = 32'($urandom_range(0, 63));
        end else begin
            r[27:26]   = 2'($urandom_range(0, 2) == 0 ? 0 : ($urandom_range(0, 1) == 0 ? 2 : 3));
            alu_data_i = $urandom;
        end
        inst_i = r;
    endtask

    int stall_cycles;

    initial begin
        for (int i = 0; i < 16; i++) begin
            ref_mem[i]  = $urandom;
            resp_mem[i] = ref_mem[i];
        end
        set_idle();
        model_reset();
        reset_i = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        compare_all();
        reset_i = 1;

        // ALU pass-through
        issue(ADD_I, 32'h0000_002A, 32'h0, 4'd3, 1'b1);
        step();
        check("alu_wb_en", {31'b0, wb_en_o}, 32'h1);
        check("alu_wb_addr", {28'b0, wb_addr_o}, 32'h3);
        check("alu_wb_data", wb_data_o, 32'h0000_002A);
        check("alu_stall", {31'b0, stall_o}, 32'h0);
        set_idle();
        step();
        check("alu_wb_en_once", {31'b0, wb_en_o}, 32'h0);

        // Word load, ack after three stalled cycles
        ref_mem[1]  = 32'hDEAD_BEEF;
        resp_mem[1] = 32'hDEAD_BEEF;
        issue(LDR_I, 32'h1000_0006, 32'h0, 4'd5, 1'b1);
        step();
        set_idle();
        check("ldr_addr", dmem_addr_o, 32'h1000_0004);
        check("ldr_be", {28'b0, dmem_be_o}, 32'hF);
        check("ldr_we", {31'b0, dmem_we_o}, 32'h0);
        stall_cycles = 0;
        for (int c = 0; c < 3; c++) begin
            if (stall_o) stall_cycles++;
            if (c == 2) begin
                dmem_ack_i   = 1;
                dmem_rdata_i = 32'hDEAD_BEEF;
            end
            step();
        end
        check("ldr_stall_cycles", 32'(stall_cycles), 32'd3);
        check("ldr_wb_en", {31'b0, wb_en_o}, 32'h1);
        check("ldr_wb_addr", {28'b0, wb_addr_o}, 32'h5);
        check("ldr_wb_data", wb_data_o, 32'hDEAD_BEEF);
        set_idle();
        step();

        // Byte store then byte load of the same address
        ref_mem[0]  = 32'h0;
        resp_mem[0] = 32'h0;
        issue(STRB_I, 32'h0000_0203, 32'h1234_56A5, 4'd9, 1'b0);
        step();
        set_idle();
        check("strb_be", {28'b0, dmem_be_o}, 32'h8);
        check("strb_wdata", dmem_wdata_o, 32'hA5A5_A5A5);
        check("strb_we", {31'b0, dmem_we_o}, 32'h1);
        dmem_ack_i = 1;
        step();
        check("strb_no_wb", {31'b0, wb_en_o}, 32'h0);
        resp_mem[0] = 32'hA500_0000;
        issue(LDRB_I, 32'h0000_0203, 32'h0, 4'd7, 1'b1);
        step();
        set_idle();
        dmem_ack_i   = 1;
        dmem_rdata_i = 32'hA500_0000;
        step();
        check("ldrb_wb_data", wb_data_o, 32'h0000_00A5);
        check("ldrb_wb_en", {31'b0, wb_en_o}, 32'h1);
        set_idle();
        step();

        // Flushed and condition-failed loads
        issue(LDR_I, 32'h0000_0010, 32'h0, 4'd2, 1'b1);
        flush_i = 1;
        step();
        check("flush_req", {31'b0, dmem_req_o}, 32'h0);
        check("flush_stall", {31'b0, stall_o}, 32'h0);
        flush_i    = 0;
        cond_met_i = 0;
        step();
        check("cond_req", {31'b0, dmem_req_o}, 32'h0);
        check("cond_wb_en", {31'b0, wb_en_o}, 32'h0);

        // Flush while a store is in flight
        issue(STR_I, 32'h0000_0008, 32'h0000_55AA, 4'd1, 1'b0);
        step();
        issue(LDR_I, 32'h0000_0004, 32'h0, 4'd4, 1'b1);
        flush_i = 1;
        step();
        check("busy_flush_req", {31'b0, dmem_req_o}, 32'h1);
        dmem_ack_i = 1;
        resp_mem[2] = 32'h0000_55AA;
        step();
        check("busy_flush_done", {31'b0, stall_o}, 32'h0);
        check("busy_flush_no_wb", {31'b0, wb_en_o}, 32'h0);
        set_idle();
        step();

        // Asynchronous reset while a load is outstanding
        issue(LDR_I, 32'h0000_000C, 32'h0, 4'd6, 1'b1);
        step();
        set_idle();
        check("pre_rst_req", {31'b0, dmem_req_o}, 32'h1);
        #2 reset_i = 0;
        #1;
        check("async_rst_req", {31'b0, dmem_req_o}, 32'h0);
        check("async_rst_stall", {31'b0, stall_o}, 32'h0);
        model_reset();
        @(negedge clk_i);
        reset_i    = 1;
        dmem_ack_i = 1;
        step();
        check("late_ack_wb_en", {31'b0, wb_en_o}, 32'h0);
        check("late_ack_req", {31'b0, dmem_req_o}, 32'h0);
        for (int i = 0; i < 16; i++) resp_mem[i] = ref_mem[i];

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            randomize_inputs();
            respond();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the five-stage ARM pipeline: it consumes the execute stage's registered result (instruction, ALU data, destination, write-enable, valid/flush) and produces the write-back bus (data, address, enable). Execute reads that bus for its register bypass. LDR/STR (word and byte) go through a request/acknowledge data-memory port with a two-state FSM. The stage stalls upstream while an access is outstanding; non-memory instructions pass through in one cycle.

## Interface
- No parameters.
- clk_i  in  1  single clock; all state updates on rising edge.
- reset_i  in  1  reset: one clock; reset is asynchronous and active-low (0 = reset).
- inst_i  in  32  instruction from execute.
- alu_data_i  in  32  ALU result; for loads/stores, the effective byte address.
- store_data_i  in  32  Rd value to store (already bypassed).
- rd_addr_i  in  4  destination register.
- do_write_i  in  1  execute's register-write request.
- cond_met_i  in  1  instruction condition passed.
- valid_i  in  1  input slot holds a live instruction.
- flush_i  in  1  kill the instruction presented this cycle.
- dmem_req_o  out  1  access request, held until ack.
- dmem_we_o  out  1  1 = store, 0 = load.
- dmem_addr_o  out  32  word address {addr[31:2],2'b00}.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  32  store data.
- dmem_ack_i  in  1  access complete; rdata valid same cycle.
- dmem_rdata_i  in  32  load data.
- wb_data_o  out  32  write-back data.
- wb_addr_o  out  4  write-back register.
- wb_en_o  out  1  write-back strobe, one cycle per retired write.
- stall_o  out  1  hold upstream (execute freezes its output registers).

## Operation
- Memory op = inst_i[27:26]==2'b01. L = inst_i[20] (1 load), B = inst_i[22] (1 byte).
- Live = valid_i & ~flush_i & cond_met_i. Dead or flushed inputs: no access, wb_en_o=0.
- FSM states IDLE, BUSY. Inputs are accepted on an edge only in IDLE.
- IDLE, live non-memory op: wb_data_o<=alu_data_i, wb_addr_o<=rd_addr_i, wb_en_o<=do_write_i.
- IDLE, live memory op: latch addr, we=~L, B, rd_addr_i, and store data; go to BUSY; wb_en_o<=0.
- BUSY: dmem_req_o=1 and all dmem_* outputs stable from latched values. Inputs ignored.
- BUSY & dmem_ack_i: go to IDLE. Load: wb_en_o<=1, wb_addr_o<=latched rd, wb_data_o<=load data. Store: wb_en_o<=0.
- Word: be=4'hF, wdata=store data, load returns dmem_rdata_i unrotated (addr[1:0] ignored).
- Byte: be=4'b0001<<addr[1:0], wdata={4{store[7:0]}}, load returns zero-extended byte addr[1:0] of rdata (little-endian: byte 0 = bits 7:0).
- flush_i never aborts an access already in BUSY; that access is older than the flushing branch and completes.
- Ack while IDLE is ignored.

## Timing
- Reset values: FSM=IDLE, dmem_req_o=0, dmem_we_o=0, dmem_addr_o=0, dmem_be_o=0, dmem_wdata_o=0, wb_data_o=0, wb_addr_o=0, wb_en_o=0, stall_o=0.
- Reset mid-BUSY: dmem_req_o drops immediately (asynchronously); the access is abandoned.
- stall_o = (state==BUSY), combinational from the state register only (no path from ack).
- dmem_* outputs are registered or decoded only from latched state; no combinational path from inst_i.
- Non-memory latency: result on wb_* one cycle after acceptance edge.
- Memory op: accept edge E. dmem_req_o high from E. Ack sampled at edge E+k (k≥1). wb_en_o pulses in cycle after E+k. Next input accepted at edge E+k+1.
- wb_en_o is never high two cycles for one instruction; it is 0 for every cycle in BUSY except the ack-completion output.

## Test plan
- Reset then ALU pass-through: after reset_i=0→1, present ADD with valid=1, cond=1, do_write=1, alu=0x0000_002A, rd=3 → next cycle wb_en_o=1, wb_addr_o=3, wb_data_o=0x2A; stall_o stays 0.
- Word load, ack after 3 cycles: LDR, alu=0x1000_0006, rd=5; rdata=0xDEAD_BEEF at ack → dmem_addr_o=0x1000_0004, be=F, we=0; stall_o high for 3 cycles; then wb_en_o=1, rd 5, data 0xDEADBEEF.
- Byte store/load: STRB, alu=0x0000_0203, store=0x1234_56A5 → be=4'b1000, wdata=0xA5A5A5A5, no wb_en_o. LDRB of the same address, rdata=0xA5000000 → wb_data_o=0x0000_00A5.
- Flush/condition kill: LDR with flush_i=1 and then with cond_met_i=0 → dmem_req_o never asserts, wb_en_o=0, stall_o=0.
- Flush during BUSY: STR in flight with flush_i=1 asserted while BUSY → request held until ack; store completes; no extra wb_en_o.
- Async reset mid-access: reset_i=0 while dmem_req_o=1 (no clock edge) → dmem_req_o, stall_o=0 immediately; after release, FSM=IDLE and a late ack is ignored.
